// File: rtl/ps2_mouse_packet_rx.sv
// ps2_mouse_packet_rx
// Assembles 3-byte PS/2 stream-mode mouse packets from the receiver byte bus.
// Byte 0 must have bit 3 set (sync bit); otherwise it is rejected with a
// sync_err pulse. A partial packet that stalls for TIMEOUT_CYCLES idle cycles
// is dropped with a timeout_err pulse. Completed packets are published as
// registered fields with a one-cycle packet_valid strobe.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   enable             stream live; low discards any partial packet silently
//   rx_data            received byte, qualified by rx_done_tick
//   rx_done_tick       one-cycle strobe for rx_data
//   packet_valid       one-cycle strobe, fields below are new
//   btn_left/right/middle, dx, dy, x_ovf, y_ovf   packet fields (held)
//   sync_err           one-cycle pulse, byte-0 candidate rejected
//   timeout_err        one-cycle pulse, partial packet dropped on timeout
//
// Handshake: a byte is consumed in the cycle where rx_done_tick=1 and
// enable=1; there is no backpressure, every qualified tick is taken.
module ps2_mouse_packet_rx #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TO_W           = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] rx_data,
  input  logic       rx_done_tick,
  output logic       packet_valid,
  output logic       btn_left,
  output logic       btn_right,
  output logic       btn_middle,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic       x_ovf,
  output logic       y_ovf,
  output logic       sync_err,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2,
    EMIT    = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  // Byte 0 without its sync bit (bit 3 is always 1 once accepted):
  // {b0[7:4], b0[2:0]}.
  logic [6:0]      b0_q, b0_d;
  logic [7:0]      b1_q, b1_d;
  logic            emit_d, sync_d, to_d;

  // Byte 2 is not kept separately: it goes straight into the low 8 bits of
  // dy on the tick that completes the packet.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    emit_d  = 1'b0;
    sync_d  = 1'b0;
    to_d    = 1'b0;

    if (!enable) begin
      // Silent resync; an EMIT in progress is already in the output regs.
      state_d = WAIT_B0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        // EMIT behaves as WAIT_B0 so back-to-back packets lose no byte.
        WAIT_B0, EMIT: begin
          state_d = WAIT_B0;
          cnt_d   = '0;
          if (rx_done_tick) begin
            if (rx_data[3]) begin
              b0_d    = {rx_data[7:4], rx_data[2:0]};
              state_d = WAIT_B1;
            end else begin
              sync_d = 1'b1;
            end
          end
        end
        WAIT_B1, WAIT_B2: begin
          // A tick on the final counter value wins over the timeout.
          if (rx_done_tick) begin
            cnt_d = '0;
            if (state_q == WAIT_B1) begin
              b1_d    = rx_data;
              state_d = WAIT_B2;
            end else begin
              emit_d  = 1'b1;
              state_d = EMIT;
            end
          end else if (cnt_q == TO_LAST) begin
            cnt_d   = '0;
            to_d    = 1'b1;
            state_d = WAIT_B0;
          end else begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end
        default: begin
          state_d = WAIT_B0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= WAIT_B0;
      cnt_q        <= '0;
      b0_q         <= '0;
      b1_q         <= '0;
      packet_valid <= 1'b0;
      sync_err     <= 1'b0;
      timeout_err  <= 1'b0;
      btn_left     <= 1'b0;
      btn_right    <= 1'b0;
      btn_middle   <= 1'b0;
      dx           <= '0;
      dy           <= '0;
      x_ovf        <= 1'b0;
      y_ovf        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      b0_q         <= b0_d;
      b1_q         <= b1_d;
      packet_valid <= emit_d;
      sync_err     <= sync_d;
      timeout_err  <= to_d;
      // Fields are loaded on entry to EMIT so they are valid together with
      // packet_valid during the EMIT cycle.
      if (emit_d) begin
        btn_left   <= b0_q[0];
        btn_right  <= b0_q[1];
        btn_middle <= b0_q[2];
        dx         <= {b0_q[3], b1_q};
        dy         <= {b0_q[4], rx_data};
        x_ovf      <= b0_q[5];
        y_ovf      <= b0_q[6];
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// Testbench for ps2_mouse_packet_rx: directed test-plan cases followed by
// randomized byte streams, gaps, enable drops and resets. A byte-level
// reference model pushes expected events (packet / sync / timeout plus the
// field values that must be visible) into exp_q; a monitor pops and compares
// whenever any output pulse is seen.
module tb_ps2_mouse_packet_rx;

  localparam int T  = 40;
  localparam int TW = 6;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] rx_data;
  logic       rx_done_tick;
  logic       packet_valid;
  logic       btn_left, btn_right, btn_middle;
  logic [8:0] dx, dy;
  logic       x_ovf, y_ovf;
  logic       sync_err, timeout_err;

  ps2_mouse_packet_rx #(.TIMEOUT_CYCLES(T), .TO_W(TW)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .rx_data      (rx_data),
    .rx_done_tick (rx_done_tick),
    .packet_valid (packet_valid),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_middle   (btn_middle),
    .dx           (dx),
    .dy           (dy),
    .x_ovf        (x_ovf),
    .y_ovf        (y_ovf),
    .sync_err     (sync_err),
    .timeout_err  (timeout_err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  // Event encoding: {kind[1:0], fields[22:0]}; kind 1=packet 2=sync 3=timeout.
  logic [24:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          now   = 0;   // index of the next driven cycle
  int          tp    = 0;   // cycle of the last byte accepted into pb
  logic [7:0]  pb[$];       // partial packet held by the model
  logic [22:0] last_f = '0; // fields the DUT must currently show

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Field layout {y_ovf, x_ovf, dy, dx, btn_middle, btn_right, btn_left}.
  function automatic logic [22:0] fields(input logic [7:0] b0,
                                         input logic [7:0] b1,
                                         input logic [7:0] b2);
    return {b0[7], b0[6], b0[5], b2, b0[4], b1, b0[2], b0[1], b0[0]};
  endfunction

  // A partial packet whose last byte was at tp survives a tick at t only if
  // t - tp <= T; otherwise it has already been dropped with a timeout.
  task automatic advance(input int t);
    if (pb.size() > 0 && (t - tp) > T) begin
      exp_q.push_back({2'd3, last_f});
      pb.delete();
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input int t);
    advance(t);
    if (pb.size() == 0) begin
      if (b[3]) begin
        pb.push_back(b);
        tp = t;
      end else begin
        exp_q.push_back({2'd2, last_f});
      end
    end else begin
      pb.push_back(b);
      tp = t;
      if (pb.size() == 3) begin
        last_f = fields(pb[0], pb[1], pb[2]);
        exp_q.push_back({2'd1, last_f});
        pb.delete();
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic en, input logic tick, input logic [7:0] d);
    @(negedge clk);
    enable       = en;
    rx_done_tick = tick;
    rx_data      = d;
    now++;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    model_byte(b, now + gap);
    repeat (gap) step(1'b1, 1'b0, 8'($urandom));
    step(1'b1, 1'b1, b);
  endtask

  task automatic idle(input int n);
    advance(now + n);
    repeat (n) step(1'b1, 1'b0, 8'h00);
  endtask

  task automatic disable_for(input int n, input int tick_at, input logic [7:0] b);
    advance(now);
    pb.delete();
    for (int i = 0; i < n; i++) step(1'b0, (i == tick_at), b);
  endtask

  task automatic do_reset(input int n);
    idle(1);
    advance(now);
    pb.delete();
    last_f = '0;
    @(negedge clk);
    rst          = 1'b1;
    rx_done_tick = 1'b0;
    now++;
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      now++;
      check("reset_outputs",
            {6'd0, packet_valid, sync_err, timeout_err, y_ovf, x_ovf, dy, dx,
             btn_middle, btn_right, btn_left}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    now++;
  endtask

  // ---------------- monitor ----------------
  logic [1:0]  mon_kind;
  logic [24:0] mon_act;
  logic [24:0] mon_exp;
  always @(negedge clk) begin
    if (packet_valid || sync_err || timeout_err) begin
      if ($countones({packet_valid, sync_err, timeout_err}) > 1) mon_kind = 2'd0;
      else if (packet_valid) mon_kind = 2'd1;
      else if (sync_err)     mon_kind = 2'd2;
      else                   mon_kind = 2'd3;
      mon_act = {mon_kind, y_ovf, x_ovf, dy, dx, btn_middle, btn_right, btn_left};
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: got 0x%0h expected none (t=%0t)", mon_act, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("event", 32'(mon_act), 32'(mon_exp));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int r, g;
  logic [7:0] rb;

  initial begin
    rst          = 1'b1;
    enable       = 1'b1;
    rx_data      = 8'h00;
    rx_done_tick = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state",
          {6'd0, packet_valid, sync_err, timeout_err, y_ovf, x_ovf, dy, dx,
           btn_middle, btn_right, btn_left}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic packet, ticks 10 cycles apart.
    send(8'h29, 0); send(8'h05, 9); send(8'hFB, 9); idle(2);
    check("p1_buttons", {btn_middle, btn_right, btn_left}, 32'b001);
    check("p1_dx", dx, 9'h005);
    check("p1_dy", dy, 9'h1FB);
    check("p1_ovf", {y_ovf, x_ovf}, 32'b00);

    // Sync rejection then a good packet.
    send(8'h00, 3); send(8'h08, 3); send(8'h10, 2); send(8'h20, 2); idle(2);
    check("p2_dx", dx, 9'h010);
    check("p2_dy", dy, 9'h020);
    check("p2_buttons", {btn_middle, btn_right, btn_left}, 32'b000);

    // Timeout then overflow packet.
    send(8'h08, 3); send(8'h01, 2); idle(T + 3);
    send(8'hCE, 2); send(8'hFF, 1); send(8'h80, 1); idle(2);
    check("p3_buttons", {btn_middle, btn_right, btn_left}, 32'b110);
    check("p3_dx", dx, 9'h0FF);
    check("p3_dy", dy, 9'h080);
    check("p3_ovf", {y_ovf, x_ovf}, 32'b11);

    // Enable drop mid-packet with an ignored tick.
    send(8'h08, 2); send(8'h01, 2); disable_for(5, 2, 8'h02);
    send(8'h09, 2); send(8'h03, 2); send(8'h04, 2); idle(2);
    check("p4_buttons", {btn_middle, btn_right, btn_left}, 32'b001);
    check("p4_dx", dx, 9'h003);
    check("p4_dy", dy, 9'h004);

    // Reset between byte1 and byte2.
    send(8'h08, 2); send(8'h01, 2); do_reset(3);
    send(8'h0A, 2); send(8'h07, 2); send(8'h07, 2); idle(2);
    check("p5_buttons", {btn_middle, btn_right, btn_left}, 32'b010);
    check("p5_dx", dx, 9'h007);
    check("p5_dy", dy, 9'h007);

    // Byte1 tick on the exact timeout cycle is accepted.
    send(8'h08, 2); send(8'h05, T - 1); send(8'h06, 3); idle(2);
    check("p6_dx", dx, 9'h005);
    check("p6_dy", dy, 9'h006);

    // One cycle too late: timeout, then 0x05 is a rejected byte-0 candidate.
    send(8'h08, 2); send(8'h05, T); idle(3);

    // Back-to-back packets (tick in EMIT) and a sync error in EMIT.
    send(8'h18, 1); send(8'h11, 0); send(8'h22, 0);
    send(8'h00, 0);
    send(8'h28, 0); send(8'h33, 0); send(8'h44, 0); idle(3);

    // Randomized traffic.
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        disable_for($urandom_range(1, 4), $urandom_range(0, 3), 8'($urandom));
      end else if (r < 6) begin
        do_reset(2);
      end else begin
        rb = 8'($urandom);
        if ($urandom_range(0, 9) < 8) rb[3] = 1'b1;
        r = $urandom_range(0, 99);
        if (r < 70)      g = $urandom_range(0, 4);
        else if (r < 85) g = $urandom_range(T - 3, T + 1);
        else             g = $urandom_range(5, T);
        send(rb, g);
      end
    end

    idle(T + 5);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_packet_rx.md
Name: ps2_mouse_packet_rx

Overview:
- Consumes the received byte stream from the PS/2 serial receiver once mouse initialisation (reset, then enable-reporting) has completed.
- Assembles each standard 3-byte stream-mode movement packet and checks byte-0 sync.
- Publishes registered button, displacement and overflow fields with a one-cycle valid strobe.
- Sits beside the reset/init command FSMs on the shared rx_data/rx_done_tick bus and feeds the cursor/position logic.

Parameters:
- TIMEOUT_CYCLES, 100000, idle cycles allowed between bytes of one packet before the partial packet is discarded (2 ms at 50 MHz).
- TO_W, 17, width of the inter-byte timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- enable  input  1  high when init is complete and the stream is live; low forces resync
- rx_data  input  8  received byte, valid when rx_done_tick=1
- rx_done_tick  input  1  one-cycle strobe: new byte on rx_data
- packet_valid  output  1  one-cycle strobe: new packet fields are valid
- btn_left  output  1  byte0[0]
- btn_right  output  1  byte0[1]
- btn_middle  output  1  byte0[2]
- dx  output  9  two's-complement X displacement, {byte0[4], byte1}
- dy  output  9  two's-complement Y displacement, {byte0[5], byte2}
- x_ovf  output  1  byte0[6]
- y_ovf  output  1  byte0[7]
- sync_err  output  1  one-cycle pulse: candidate byte0 rejected because bit3=0
- timeout_err  output  1  one-cycle pulse: partial packet dropped on inter-byte timeout

Behaviour:
- Reset: state WAIT_B0; all outputs 0; internal byte registers 0; timeout counter 0.
- States: WAIT_B0, WAIT_B1, WAIT_B2, EMIT.
- WAIT_B0:
  - on rx_done_tick with enable=1 and rx_data[3]=1: latch byte0, clear counter, go to WAIT_B1.
  - on rx_done_tick with enable=1 and rx_data[3]=0: pulse sync_err next cycle, stay in WAIT_B0, discard the byte.
  - counter is held at 0 in this state.
- WAIT_B1:
  - on tick: latch byte1, clear counter, go to WAIT_B2.
  - otherwise the counter increments each cycle.
  - when the counter equals TIMEOUT_CYCLES-1 with no tick: go to WAIT_B0 and pulse timeout_err.
- WAIT_B2:
  - on tick: latch byte2 and go to EMIT.
  - timeout handling is the same as WAIT_B1.
- EMIT (one cycle):
  - load all output fields from byte0/byte1/byte2 and assert packet_valid for exactly this cycle.
  - go to WAIT_B0.
  - a tick arriving in EMIT is processed as a WAIT_B0 byte.
- Latency: packet_valid rises 1 cycle after the rx_done_tick of byte2.
- Field outputs are registered and hold their value until the next EMIT; sync_err and timeout_err do not alter them.
- No byte-value filtering beyond the bit3 check (0xFA/0xAA are not special-cased here; upstream FSMs own those).
- enable=0:
  - rx_done_tick is ignored in every state.
  - any partial packet is discarded at once: state becomes WAIT_B0 on the next clock and the counter clears.
  - no error pulse is generated.
  - if the FSM is in EMIT, the emit still completes.
- Simultaneous tick and timeout in the same cycle: the tick wins, the byte is accepted and no timeout_err is raised.
- All pulses (packet_valid, sync_err, timeout_err) last exactly one cycle and are mutually exclusive.
- Reset mid-packet: immediate return to the reset state. Partial bytes are lost and no pulse is generated.
- dx/dy are raw 9-bit signed values. No saturation or sign manipulation is applied, even when the overflow bits are set.

Test Plan:
- enable=1; bytes 0x29, 0x05, 0xFB with ticks 10 cycles apart -> packet_valid one cycle after the third tick; btn_left=1, btn_right=0, btn_middle=0, dx=9'h005, dy=9'h1FB (-5), x_ovf=0, y_ovf=0.
- Byte 0x00, then 0x08, 0x10, 0x20 -> sync_err pulse after 0x00 with no state advance; then a packet with dx=9'h010, dy=9'h020, all buttons 0.
- Bytes 0x08, 0x01, then silence for TIMEOUT_CYCLES -> timeout_err pulse, no packet_valid; a following 0xCE, 0xFF, 0x80 gives btn_right=1, btn_middle=1, dx=9'h0FF, dy=9'h080, x_ovf=1, y_ovf=1.
- Bytes 0x08, 0x01, then enable=0 for 5 cycles with a tick of 0x02 during it, then enable=1 and 0x09, 0x03, 0x04 -> one packet only: btn_left=1, dx=3, dy=4; no error pulses.
- Assert rst between byte1 and byte2, then send 0x0A, 0x07, 0x07 -> outputs 0 during reset; then btn_right=1, dx=7, dy=7.
- Byte 0x08, then a byte1 tick landing on the exact timeout cycle -> byte accepted, no timeout_err; the packet completes normally with byte2.
